// File: rtl/im_loader_if.sv
// Instruction-word stream into the program loader: valid/ready handshake with
// a last-beat marker.
interface im_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/im_loader.sv
// Program loader: streams instruction words into the instruction memory and
// holds the CPU until an image is complete. Optional macro: IM_LOADER_CHECKSUM_EN.
module im_loader #(
    parameter int          DEPTH     = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
    parameter int          CNT_W     = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    im_loader_if.slave       in_if,
    output logic             im_we,
    output logic [31:0]      im_addr,
    output logic [31:0]      im_wdata,
    output logic             cpu_hold,
    output logic             done,
    output logic             overflow,
    output logic [CNT_W-1:0] word_count
`ifdef IM_LOADER_CHECKSUM_EN
    ,
    output logic             csum_err
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

    state_t           state_q;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic             hold_q;
    logic             done_q;
    logic             ovf_q;
    logic [CNT_W-1:0] cnt_q;

    logic             hs;
    logic             full;
    logic             csum_ok;
    logic [31:0]      addr_d;

    assign in_if.in_ready = (state_q == LOAD);
    assign hs             = in_if.in_valid & in_if.in_ready;
    assign full           = (cnt_q == CNT_W'(DEPTH));
    assign addr_d         = BASE_ADDR + (32'(cnt_q) << 2);

`ifdef IM_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;

    logic [31:0] csum_q;
    logic        csum_err_q;
    logic        data_wr;

    // The last beat carries the checksum, so it never enters the running XOR.
    assign data_wr  = hs & ~full & ~in_if.in_last;
    assign csum_ok  = (in_if.in_data == csum_q);
    assign csum_err = csum_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum_q     <= '0;
            csum_err_q <= 1'b0;
        end else if (state_q != LOAD && start) begin
            csum_q     <= '0;
            csum_err_q <= 1'b0;
        end else if (data_wr) begin
            csum_q <= csum_q ^ in_if.in_data;
        end else if (hs && in_if.in_last && !csum_ok) begin
            csum_err_q <= 1'b1;
        end
    end
`else
    localparam bit CSUM_EN = 1'b0;
    assign csum_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state_q <= LOAD;
                        cnt_q   <= '0;
                        hold_q  <= 1'b1;
                        done_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (hs) begin
                        if (CSUM_EN && in_if.in_last) begin
                            state_q <= csum_ok ? DONE : ERR;
                            done_q  <= csum_ok;
                            hold_q  <= ~csum_ok;
                        end else if (full) begin
                            state_q <= ERR;
                            ovf_q   <= 1'b1;
                        end else begin
                            we_q    <= 1'b1;
                            addr_q  <= addr_d;
                            wdata_q <= in_if.in_data;
                            cnt_q   <= cnt_q + 1'b1;
                            if (in_if.in_last) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                                hold_q  <= 1'b0;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign im_we      = we_q;
    assign im_addr    = addr_q;
    assign im_wdata   = wdata_q;
    assign cpu_hold   = hold_q;
    assign done       = done_q;
    assign overflow   = ovf_q;
    assign word_count = cnt_q;

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: vector table for the main load flows,
// hand sequences for reset and checksum corners, scoreboard for memory writes.
module tb_im_loader;

    localparam int          DEPTH = 4;
    localparam int          CNT_W = 3;
    localparam logic [31:0] BASE  = 32'h0000_3000;
`ifdef IM_LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             im_we;
    logic [31:0]      im_addr;
    logic [31:0]      im_wdata;
    logic             cpu_hold;
    logic             done;
    logic             overflow;
    logic [CNT_W-1:0] word_count;
`ifdef IM_LOADER_CHECKSUM_EN
    logic             csum_err;
`endif

    im_loader_if bus ();

    im_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_if     (bus),
        .im_we     (im_we),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .overflow  (overflow),
        .word_count(word_count)
`ifdef IM_LOADER_CHECKSUM_EN
        ,
        .csum_err  (csum_err)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;
    wr_t q[$];

    typedef enum {M_IDLE, M_LOAD, M_DONE, M_ERR} mstate_t;
    mstate_t     mstate = M_IDLE;
    int          mcount = 0;
    logic [31:0] mxor   = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Writes land one cycle after the accepting edge; the monitor checks the cycle too.
    always @(negedge clk) begin
        wr_t e;
        if (im_we === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_write: got addr %h data %h, required no write", im_addr, im_wdata);
            end else begin
                e = q.pop_front();
                chk("wr_addr", im_addr, e.addr);
                chk("wr_data", im_wdata, e.data);
                chk("wr_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic step(input bit s, input bit v, input bit l, input logic [31:0] d);
        start       = s;
        bus.in_valid = v;
        bus.in_last  = l;
        bus.in_data  = d;
        chk("in_ready", {31'b0, bus.in_ready}, {31'b0, mstate == M_LOAD});
        if (mstate != M_LOAD) begin
            if (s) begin
                mstate = M_LOAD;
                mcount = 0;
                mxor   = '0;
            end
        end else if (v) begin
            if (CSUM && l) begin
                mstate = (d == mxor) ? M_DONE : M_ERR;
            end else if (mcount == DEPTH) begin
                mstate = M_ERR;
            end else begin
                q.push_back('{BASE + 32'(mcount) * 4, d, cyc + 1});
                mxor   = mxor ^ d;
                mcount = mcount + 1;
                if (l) mstate = M_DONE;
            end
        end
        @(posedge clk);
        #1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    typedef struct {
        bit          s, v, l;
        logic [31:0] d;
        bit          e_done, e_hold, e_ovf;
        int          e_cnt;
    } vec_t;
    vec_t tbl[25];

    initial begin
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = '0;

        #2 reset = 1'b1;
        #2;
        chk("rst_hold",  {31'b0, cpu_hold}, 32'd1);
        chk("rst_addr",  im_addr, BASE);
        chk("rst_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("rst_we",    {31'b0, im_we}, 32'd0);
        chk("rst_wdata", im_wdata, 32'd0);
        chk("rst_done",  {31'b0, done}, 32'd0);
        chk("rst_ovf",   {31'b0, overflow}, 32'd0);
        chk("rst_cnt",   32'(word_count), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

`ifndef IM_LOADER_CHECKSUM_EN
        //            s  v  l  data            done hold ovf cnt
        tbl[0]  = '{1, 0, 0, 32'h0,          0, 1, 0, 0};
        tbl[1]  = '{0, 1, 0, 32'h3C01_0000,  0, 1, 0, 1};
        tbl[2]  = '{0, 1, 0, 32'h3421_0004,  0, 1, 0, 2};
        tbl[3]  = '{0, 1, 1, 32'h0000_0000,  1, 0, 0, 3};
        tbl[4]  = '{0, 1, 0, 32'hAAAA_0000,  1, 0, 0, 3};
        tbl[5]  = '{1, 1, 0, 32'hDEAD_BEEF,  0, 1, 0, 0};
        tbl[6]  = '{0, 1, 0, 32'hA1A1_A1A1,  0, 1, 0, 1};
        tbl[7]  = '{0, 0, 0, 32'hFFFF_FFFF,  0, 1, 0, 1};
        tbl[8]  = '{0, 1, 0, 32'hB2B2_B2B2,  0, 1, 0, 2};
        tbl[9]  = '{0, 0, 0, 32'hEEEE_EEEE,  0, 1, 0, 2};
        tbl[10] = '{0, 1, 0, 32'hC3C3_C3C3,  0, 1, 0, 3};
        tbl[11] = '{0, 1, 0, 32'hD4D4_D4D4,  0, 1, 0, 4};
        tbl[12] = '{0, 1, 0, 32'hE5E5_E5E5,  0, 1, 1, 4};
        tbl[13] = '{0, 1, 0, 32'hF6F6_F6F6,  0, 1, 1, 4};
        tbl[14] = '{1, 0, 0, 32'h0,          0, 1, 0, 0};
        tbl[15] = '{1, 1, 0, 32'h0000_0011,  0, 1, 0, 1};
        tbl[16] = '{0, 1, 1, 32'h0000_0022,  1, 0, 0, 2};
        tbl[17] = '{1, 0, 0, 32'h0,          0, 1, 0, 0};
        tbl[18] = '{0, 1, 1, 32'h1234_5678,  1, 0, 0, 1};
        tbl[19] = '{1, 0, 0, 32'h0,          0, 1, 0, 0};
        tbl[20] = '{0, 1, 0, 32'h0000_0001,  0, 1, 0, 1};
        tbl[21] = '{0, 1, 0, 32'h0000_0002,  0, 1, 0, 2};
        tbl[22] = '{0, 1, 0, 32'h0000_0003,  0, 1, 0, 3};
        tbl[23] = '{0, 1, 0, 32'h0000_0004,  0, 1, 0, 4};
        tbl[24] = '{0, 1, 1, 32'h0000_0099,  0, 1, 1, 4};

        for (int i = 0; i < 25; i++) begin
            step(tbl[i].s, tbl[i].v, tbl[i].l, tbl[i].d);
            chk($sformatf("v%0d_done", i), {31'b0, done},     {31'b0, tbl[i].e_done});
            chk($sformatf("v%0d_hold", i), {31'b0, cpu_hold}, {31'b0, tbl[i].e_hold});
            chk($sformatf("v%0d_ovf", i),  {31'b0, overflow}, {31'b0, tbl[i].e_ovf});
            chk($sformatf("v%0d_cnt", i),  32'(word_count),   32'(tbl[i].e_cnt));
        end
        chk("addr_hold", im_addr, 32'h0000_300C);
`else
        step(1, 0, 0, 32'h0);
        step(0, 1, 0, 32'h1111_1111);
        step(0, 1, 0, 32'h2222_2222);
        step(0, 1, 1, 32'h3333_3333);
        chk("cs_ok_done", {31'b0, done}, 32'd1);
        chk("cs_ok_hold", {31'b0, cpu_hold}, 32'd0);
        chk("cs_ok_cnt",  32'(word_count), 32'd2);
        chk("cs_ok_err",  {31'b0, csum_err}, 32'd0);
        step(1, 0, 0, 32'h0);
        step(0, 1, 0, 32'h1111_1111);
        step(0, 1, 0, 32'h2222_2222);
        step(0, 1, 1, 32'h3333_3334);
        chk("cs_bad_done", {31'b0, done}, 32'd0);
        chk("cs_bad_hold", {31'b0, cpu_hold}, 32'd1);
        chk("cs_bad_cnt",  32'(word_count), 32'd2);
        chk("cs_bad_err",  {31'b0, csum_err}, 32'd1);
        step(1, 0, 0, 32'h0);
        chk("cs_clr_err",  {31'b0, csum_err}, 32'd0);
        chk("cs_clr_cnt",  32'(word_count), 32'd0);
        step(0, 0, 0, 32'h0);
`endif

        // Asynchronous reset while the second write is on the port.
        if (mstate == M_LOAD) step(0, 0, 0, 32'h0);
        else step(1, 0, 0, 32'h0);
        step(0, 1, 0, 32'h0BAD_0001);
        step(0, 1, 0, 32'h0BAD_0002);
        #5;
        chk("mid_we_before", {31'b0, im_we}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_we",    {31'b0, im_we}, 32'd0);
        chk("mid_hold",  {31'b0, cpu_hold}, 32'd1);
        chk("mid_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("mid_cnt",   32'(word_count), 32'd0);
        chk("mid_addr",  im_addr, BASE);
        #1 reset = 1'b0;
        mstate = M_IDLE;
        mcount = 0;
        @(posedge clk);
        #1;
        step(0, 1, 0, 32'h0BAD_0003);
        chk("post_rst_cnt", 32'(word_count), 32'd0);
        step(1, 0, 0, 32'h0);
        step(0, 1, 0, 32'h0600_D000);
        chk("post_rst_cnt1", 32'(word_count), 32'd1);

        step(0, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        chk("sb_empty", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
